// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU request arbiter and its
// bench.
//   DATA_WIDTH     - ALU operand/result width
//   OP_ADD, OP_SUB - single-bit opcode encodings understood by simple_alu
//   arb_state_e    - arbiter FSM state encoding
package alu_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT_DONE,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: serial operand bus between the arbiter and simple_alu.
//   opcode_valid - high for the first (operand A) beat of a transaction
//   opcode       - 0 = add, 1 = subtract; meaningful with opcode_valid
//   data         - operand A on the opcode_valid beat, operand B on the next
//   done         - one-cycle completion pulse from the ALU
//   result       - ALU result, valid with done
//   overflow     - ALU overflow flag, valid with done
// Modports: master = arbiter side, slave = ALU side.
interface alu_req_arbiter_if #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
);

  logic                  opcode_valid;
  logic                  opcode;
  logic [DATA_WIDTH-1:0] data;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  overflow;

  modport master (
    output opcode_valid, opcode, data,
    input  done, result, overflow
  );

  modport slave (
    input  opcode_valid, opcode, data,
    output done, result, overflow
  );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selection.
//   req       - request vector
//   rr_ptr    - index with highest priority this round
//   grant     - one-hot grant of the first set req bit at or above rr_ptr,
//               wrapping modulo NUM_REQ; all zero when req is empty
//   grant_idx - binary index of the granted bit (0 when req is empty)
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  localparam int CW = PTR_W + 1;

  logic [CW-1:0] cand;
  logic          found;

  // Walk candidates rr_ptr, rr_ptr+1, ... with an explicit wrap so that
  // NUM_REQ need not be a power of two; the first pending one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[PTR_W-1:0]]  = 1'b1;
        grant_idx               = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one simple_alu among NUM_REQ requesters.
// Grants round-robin, sends A then B over the serial ALU bus, waits for done
// (or gives up after TIMEOUT cycles) and pulses the result back to the
// granted requester.
//   clk, reset_n  - clock; asynchronous active-low reset
//   req           - per-requester request level, held until its rsp_valid
//   req_opcode    - per-requester opcode bit
//   req_a, req_b  - packed operands, slice i belongs to requester i
//   rsp_valid     - one-hot, one-cycle completion pulse
//   rsp_result    - result, zero unless rsp_valid
//   rsp_overflow  - ALU overflow, zero unless rsp_valid
//   rsp_timeout   - transaction aborted, zero unless rsp_valid
//   alu           - master side of the ALU operand bus
module alu_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_opcode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow,
  output logic                          rsp_timeout,
  alu_req_arbiter_if.master             alu
);

  import alu_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e state_q, state_d;

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]      grant_idx_q, grant_idx_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  opv_q, opv_d;
  logic                  opc_q, opc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]    rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_d;
  logic                  rsp_overflow_d;
  logic                  rsp_timeout_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [PTR_W-1:0]      pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  assign alu.opcode_valid = opv_q;
  assign alu.opcode       = opc_q;
  assign alu.data         = data_q;

  // Every output is a register, so each state computes the values the
  // outputs must carry in the *next* state. Operand A is therefore loaded
  // straight into the data register at grant time, and only B needs a
  // holding register.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    grant_idx_d    = grant_idx_q;
    b_d            = b_q;
    cnt_d          = cnt_q;
    opv_d          = 1'b0;
    opc_d          = OP_ADD;
    data_d         = '0;
    rsp_valid_d    = '0;
    rsp_result_d   = '0;
    rsp_overflow_d = 1'b0;
    rsp_timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d     = ST_SEND_A;
          grant_d     = pick_grant;
          grant_idx_d = pick_idx;
          b_d         = req_b[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          opv_d       = 1'b1;
          opc_d       = req_opcode[pick_idx];
          data_d      = req_a[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ST_SEND_A: begin
        state_d = ST_SEND_B;
        data_d  = b_q;
      end
      ST_SEND_B: begin
        state_d = ST_WAIT_DONE;
        cnt_d   = '0;
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        // done wins over an expiring counter in the same cycle
        if (alu.done) begin
          state_d        = ST_RESP;
          rsp_valid_d    = grant_q;
          rsp_result_d   = alu.result;
          rsp_overflow_d = alu.overflow;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d       = ST_RESP;
          rsp_valid_d   = grant_q;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      opv_q        <= 1'b0;
      opc_q        <= 1'b0;
      data_q       <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      opv_q        <= opv_d;
      opc_q        <= opc_d;
      data_q       <= data_d;
      rsp_valid    <= rsp_valid_d;
      rsp_result   <= rsp_result_d;
      rsp_overflow <= rsp_overflow_d;
      rsp_timeout  <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed bench for alu_req_arbiter with a behavioural
// simple_alu model on the slave side of the bus. Stimulus pushes the
// hand-computed response into a queue; a monitor pops and compares whenever
// rsp_valid is seen.
module tb_alu_req_arbiter;

  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int TMO     = 64;

  typedef struct packed {
    logic [NUM_REQ-1:0] valid;
    logic [DW-1:0]      result;
    logic               ovf;
    logic               tmo;
  } exp_t;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_opcode;
  logic [NUM_REQ*DW-1:0] req_a;
  logic [NUM_REQ*DW-1:0] req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_result;
  logic                  rsp_overflow;
  logic                  rsp_timeout;

  logic                  suppress_done;
  logic                  spur_done;

  logic [1:0]            alu_phase;
  logic                  alu_op;
  logic [DW-1:0]         alu_a;
  logic [DW-1:0]         alu_b;
  logic                  model_done;
  logic [DW-1:0]         model_result;
  logic                  model_ovf;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  alu_req_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  alu_req_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_timeout  (rsp_timeout),
    .alu          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: A beat, B beat, one compute cycle, then a done pulse.
  // Overflow is the unsigned carry (add) or borrow (subtract).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_phase    <= 2'd0;
      alu_op       <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      model_done   <= 1'b0;
      model_result <= '0;
      model_ovf    <= 1'b0;
    end else begin
      model_done   <= 1'b0;
      model_result <= '0;
      model_ovf    <= 1'b0;
      case (alu_phase)
        2'd0: if (bus.opcode_valid) begin
          alu_a     <= bus.data;
          alu_op    <= bus.opcode;
          alu_phase <= 2'd1;
        end
        2'd1: begin
          alu_b     <= bus.data;
          alu_phase <= 2'd2;
        end
        2'd2: alu_phase <= 2'd3;
        default: begin
          if (!suppress_done) begin
            model_done <= 1'b1;
            {model_ovf, model_result} <= (alu_op == OP_SUB) ?
                ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
          end
          alu_phase <= 2'd0;
        end
      endcase
    end
  end

  assign bus.done     = model_done | spur_done;
  assign bus.result   = model_result;
  assign bus.overflow = model_ovf;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic op,
                                input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_opcode[idx]     = op;
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
    req[idx]            = 1'b1;
  endtask

  task automatic push_exp(input int idx, input logic [DW-1:0] res,
                          input logic ovf, input logic tmo);
    exp_t e;
    e.valid      = '0;
    e.valid[idx] = 1'b1;
    e.result     = res;
    e.ovf        = ovf;
    e.tmo        = tmo;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge where rsp_valid is seen, so the caller can drop
  // req in that same cycle.
  task automatic wait_rsp(input string name, input int max_cycles, output int seen_cyc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) got = 1'b1;
    end
    check_output({name, "_rsp_arrives"}, 32'(got), 32'd1);
    seen_cyc = cyc;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check_output("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("rsp_valid",    32'(rsp_valid),    32'(e.valid));
          check_output("rsp_result",   32'(rsp_result),   32'(e.result));
          check_output("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
          check_output("rsp_timeout",  32'(rsp_timeout),  32'(e.tmo));
        end
      end else begin
        check_output("rsp_quiet_zero", {23'd0, rsp_result, rsp_overflow}, 32'd0);
        check_output("rsp_quiet_tmo",  32'(rsp_timeout), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int c;
    int d;
    logic got;

    reset_n       = 1'b0;
    req           = '0;
    req_opcode    = '0;
    req_a         = '0;
    req_b         = '0;
    suppress_done = 1'b0;
    spur_done     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_alu_opv",   32'(bus.opcode_valid), 32'd0);
    check_output("reset_alu_data",  32'(bus.data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("idle_alu_opv", 32'(bus.opcode_valid), 32'd0);

    // Single request: 12 + 34
    $display("[TB] single request");
    apply_stimulus(0, OP_ADD, 8'h12, 8'h34);
    push_exp(0, 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    check_output("single_opv_t1",  32'(bus.opcode_valid), 32'd1);
    check_output("single_opc_t1",  32'(bus.opcode), 32'(OP_ADD));
    check_output("single_data_t1", 32'(bus.data), 32'h12);
    @(negedge clk);
    check_output("single_opv_t2",  32'(bus.opcode_valid), 32'd0);
    check_output("single_data_t2", 32'(bus.data), 32'h34);
    got = 1'b0;
    d   = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        d   = cyc;
      end
    end
    check_output("single_done_seen", 32'(got), 32'd1);
    @(negedge clk);
    check_output("single_rsp_at_done_plus1", 32'(rsp_valid), 32'b0001);
    check_output("single_rsp_cycle", 32'(cyc), 32'(d + 1));
    req[0] = 1'b0;

    // Overflow: F0 + 20
    $display("[TB] overflow");
    @(negedge clk);
    apply_stimulus(2, OP_ADD, 8'hF0, 8'h20);
    push_exp(2, 8'h10, 1'b1, 1'b0);
    wait_rsp("overflow", 40, c);
    req[2] = 1'b0;

    // Spurious done in IDLE and in SEND_B
    $display("[TB] spurious done");
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check_output("spur_idle_no_opv", 32'(bus.opcode_valid), 32'd0);
    @(negedge clk);
    check_output("spur_idle_no_rsp", 32'(rsp_valid), 32'd0);
    apply_stimulus(3, OP_SUB, 8'h50, 8'h20);
    push_exp(3, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    check_output("spur_opv_t1",  32'(bus.opcode_valid), 32'd1);
    check_output("spur_opc_t1",  32'(bus.opcode), 32'(OP_SUB));
    @(negedge clk);
    spur_done = 1'b1;
    check_output("spur_sendb_data", 32'(bus.data), 32'h20);
    @(negedge clk);
    spur_done = 1'b0;
    wait_rsp("spurious", 40, c);
    req[3] = 1'b0;

    // Round robin with all four requests held
    $display("[TB] round robin");
    @(negedge clk);
    apply_stimulus(0, OP_ADD, 8'h01, 8'h02);
    apply_stimulus(1, OP_SUB, 8'h05, 8'h07);
    apply_stimulus(2, OP_ADD, 8'h80, 8'h80);
    apply_stimulus(3, OP_ADD, 8'h7F, 8'h01);
    push_exp(0, 8'h03, 1'b0, 1'b0);
    push_exp(1, 8'hFE, 1'b1, 1'b0);
    push_exp(2, 8'h00, 1'b1, 1'b0);
    push_exp(3, 8'h80, 1'b0, 1'b0);
    push_exp(0, 8'h03, 1'b0, 1'b0);
    push_exp(1, 8'hFE, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      wait_rsp("rr", 40, c);
      if (k == 5) begin
        req = '0;
      end else begin
        @(negedge clk);
        check_output("rr_idle_gap", 32'(bus.opcode_valid), 32'd0);
        @(negedge clk);
        check_output("rr_regrant", 32'(bus.opcode_valid), 32'd1);
      end
    end

    // Timeout: no done from the ALU
    $display("[TB] timeout");
    @(negedge clk);
    suppress_done = 1'b1;
    apply_stimulus(1, OP_ADD, 8'h11, 8'h22);
    push_exp(1, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check_output("tmo_opv_t1", 32'(bus.opcode_valid), 32'd1);
    s = cyc;
    wait_rsp("timeout", 100, c);
    check_output("tmo_latency", 32'(c), 32'(s + 2 + TMO));
    req[1]        = 1'b0;
    suppress_done = 1'b0;

    // Reset during WAIT_DONE for requester 3
    $display("[TB] reset mid-operation");
    @(negedge clk);
    apply_stimulus(3, OP_ADD, 8'h44, 8'h55);
    @(negedge clk);
    check_output("rstmid_opv_t1", 32'(bus.opcode_valid), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    #1;
    check_output("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rstmid_alu_opv",   32'(bus.opcode_valid), 32'd0);
    check_output("rstmid_alu_data",  32'(bus.data), 32'd0);
    check_output("rstmid_rsp_bits",  {23'd0, rsp_result, rsp_timeout}, 32'd0);
    repeat (3) @(negedge clk);
    apply_stimulus(1, OP_ADD, 8'h0A, 8'h0B);
    apply_stimulus(3, OP_ADD, 8'hFF, 8'hFF);
    push_exp(1, 8'h15, 1'b0, 1'b0);
    push_exp(3, 8'hFE, 1'b1, 1'b0);
    reset_n = 1'b1;
    wait_rsp("post_reset_first", 40, c);
    req[1] = 1'b0;
    wait_rsp("post_reset_second", 40, c);
    req[3] = 1'b0;

    repeat (10) @(negedge clk);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
